// File: rtl/gate_selftest_seq.sv
// gate_selftest_seq
// Purpose : self-test sequencer for the two-input logic-gate block. It walks
//           the operands through 00, 01, 10, 11, holds each vector for
//           HOLD_CYCLES cycles and then compares the seven gate outputs
//           against a fixed truth table.
// Latency : done pulses 4*HOLD_CYCLES edges after start is accepted.
//           Back-to-back runs are separated by one DONE and one IDLE cycle.
// Backpressure: none. start is level-sampled in IDLE only and is ignored in
//           RUN and DONE.
// Ports   : clk/rst_n      clock, async active-low reset
//           start          run request
//           a, b           registered operands driven to the gate block
//           gate_out       gate block results {v,u,t,s,r,q,p}
//           busy, done     run in progress / one-cycle completion pulse
//           pass           last run had zero mismatching bits
//           fail_vec       per-vector mismatch flags
//           fail_bits      sticky OR of mismatching gate_out bit positions
//           err_count      total mismatching bits in the run (0..28)
module gate_selftest_seq #(
    parameter int unsigned HOLD_CYCLES = 4   // legal range 2..255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic [6:0] gate_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_vec,
    output logic [6:0] fail_bits,
    output logic [4:0] err_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // 8 bits covers the largest legal hold counter value (254).
    localparam int unsigned     HC_W    = 8;
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(HOLD_CYCLES - 1);

    state_e          state_q, state_d;
    logic [1:0]      vi_q, vi_d;
    logic [HC_W-1:0] hc_q, hc_d;
    logic            a_q, a_d;
    logic            b_q, b_d;
    logic            pass_q, pass_d;
    logic [3:0]      fail_vec_q, fail_vec_d;
    logic [6:0]      fail_bits_q, fail_bits_d;
    logic [4:0]      err_count_q, err_count_d;

    logic [6:0]      mm;
    logic [4:0]      err_sum;
    logic [1:0]      vi_next;

    // Golden gate outputs for operand pair {a,b} = vi.
    function automatic logic [6:0] expected_out(input logic [1:0] vi);
        logic [6:0] e;
        case (vi)
            2'd0:    e = 7'h59;
            2'd1:    e = 7'h2D;
            2'd2:    e = 7'h2C;
            default: e = 7'h46;
        endcase
        return e;
    endfunction

    function automatic logic [2:0] popcount7(input logic [6:0] x);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 7; i++) begin
            n = n + {2'b00, x[i]};
        end
        return n;
    endfunction

    // Mismatch terms are always computed but only committed on compare edges.
    assign mm      = gate_out ^ expected_out(vi_q);
    assign err_sum = err_count_q + {2'b00, popcount7(mm)};
    assign vi_next = vi_q + 2'd1;

    always_comb begin
        state_d     = state_q;
        vi_d        = vi_q;
        hc_d        = hc_q;
        a_d         = a_q;
        b_d         = b_q;
        pass_d      = pass_q;
        fail_vec_d  = fail_vec_q;
        fail_bits_d = fail_bits_q;
        err_count_d = err_count_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_RUN;
                    vi_d        = 2'd0;
                    hc_d        = '0;
                    a_d         = 1'b0;
                    b_d         = 1'b0;
                    pass_d      = 1'b0;
                    fail_vec_d  = 4'd0;
                    fail_bits_d = 7'd0;
                    err_count_d = 5'd0;
                end
            end
            ST_RUN: begin
                if (hc_q == HC_LAST) begin
                    err_count_d = err_sum;
                    fail_bits_d = fail_bits_q | mm;
                    fail_vec_d  = fail_vec_q | ({3'b000, |mm} << vi_q);
                    hc_d        = '0;
                    if (vi_q == 2'd3) begin
                        state_d = ST_DONE;
                        vi_d    = 2'd0;
                        a_d     = 1'b0;
                        b_d     = 1'b0;
                        // Uses the post-compare total so the last vector counts.
                        pass_d  = (err_sum == 5'd0);
                    end else begin
                        // Next vector goes out on the same edge as this compare.
                        vi_d = vi_next;
                        a_d  = vi_next[1];
                        b_d  = vi_next[0];
                    end
                end else begin
                    hc_d = hc_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            vi_q        <= 2'd0;
            hc_q        <= '0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            pass_q      <= 1'b0;
            fail_vec_q  <= 4'd0;
            fail_bits_q <= 7'd0;
            err_count_q <= 5'd0;
        end else begin
            state_q     <= state_d;
            vi_q        <= vi_d;
            hc_q        <= hc_d;
            a_q         <= a_d;
            b_q         <= b_d;
            pass_q      <= pass_d;
            fail_vec_q  <= fail_vec_d;
            fail_bits_q <= fail_bits_d;
            err_count_q <= err_count_d;
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign pass      = pass_q;
    assign fail_vec  = fail_vec_q;
    assign fail_bits = fail_bits_q;
    assign err_count = err_count_q;

endmodule
